// File: rtl/hyperbus_phy2r.sv
// Packs PHY read words into AXI R beats, honouring AXI size, start address and length.
// Latency: one cycle from the accepted PHY word to R valid, through a registered beat buffer.
// Backpressure: PHY is stalled outside Fill; R beat held stable while axi_ready_i is low. Option: HYPERBUS_PHY2R_ZERO_FILL_EN.
module hyperbus_phy2r #(
    parameter int AxiDataWidth = 64,
    parameter int NumPhys      = 2,
    parameter int BurstLength  = 8,
    parameter int AddrWidth    = $clog2(AxiDataWidth/8)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [2:0]               size,
    input  logic [AddrWidth-1:0]     start_addr,
    input  logic [BurstLength-1:0]   len,
    input  logic                     is_a_read,
    input  logic                     trans_handshake,
    input  logic                     phy_valid_i,
    output logic                     phy_ready_o,
    input  logic [16*NumPhys-1:0]    data_i,
    input  logic                     last_i,
    output logic                     axi_valid_o,
    input  logic                     axi_ready_i,
    output logic [AxiDataWidth-1:0]  data_o,
    output logic                     last_o
);

    localparam int PhyBytes = 2 * NumPhys;
    localparam int PhyW     = 16 * NumPhys;
    localparam logic [AddrWidth:0]   PhyBytesExt = (AddrWidth+1)'(PhyBytes);
    localparam logic [AddrWidth-1:0] PhyBytesA   = AddrWidth'(PhyBytes);
    localparam logic [AddrWidth-1:0] PhyMask     = AddrWidth'(PhyBytes - 1);
    localparam logic [AddrWidth:0]   OneExt      = (AddrWidth+1)'(1);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Fill = 2'd1,
        Send = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [2:0]               size_q, size_d;
    logic [BurstLength-1:0]   len_q, len_d;
    logic [AddrWidth-1:0]     byte_idx_q, byte_idx_d;
    logic [AddrWidth-1:0]     phy_idx_q, phy_idx_d;
    logic [BurstLength-1:0]   beat_cnt_q, beat_cnt_d;
    logic                     phy_last_q, phy_last_d;
    logic [AxiDataWidth-1:0]  buf_q, buf_d;

    logic [2:0]               size_eff;
    logic [AddrWidth:0]       nbytes;
    logic [AddrWidth:0]       beat_end;
    logic [AddrWidth:0]       phy_next;
    logic [AddrWidth-1:0]     byte_next;
    logic [AddrWidth-1:0]     word_base;
    logic                     narrow;
    logic                     in_held_word;
    logic                     beat_last;
    logic                     new_read;

    // A size wider than the bus cannot be legal AXI; clamp so the beat arithmetic stays in range.
    assign size_eff     = (int'(size_q) > AddrWidth) ? 3'(AddrWidth) : size_q;
    assign nbytes       = OneExt << size_eff;
    assign beat_end     = ({1'b0, byte_idx_q} & ~(nbytes - OneExt)) + nbytes;
    assign phy_next     = {1'b0, phy_idx_q} + PhyBytesExt;
    assign byte_next    = beat_end[AddrWidth-1:0];
    assign word_base    = phy_idx_q - PhyBytesA;
    assign narrow       = nbytes < PhyBytesExt;
    assign in_held_word = (byte_next & ~PhyMask) == word_base;
    assign beat_last    = (beat_cnt_q == len_q) || phy_last_q;
    assign new_read     = trans_handshake && is_a_read;

    assign phy_ready_o  = (state_q == Fill);
    assign axi_valid_o  = (state_q == Send);
    assign data_o       = (state_q == Send) ? buf_q : '0;
    assign last_o       = (state_q == Send) && beat_last;

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        phy_idx_d  = phy_idx_q;
        beat_cnt_d = beat_cnt_q;
        phy_last_d = phy_last_q;
        buf_d      = buf_q;

        unique case (state_q)
            Idle: begin
                if (new_read) begin
                    state_d = Fill;
                end
            end
            Fill: begin
                if (phy_valid_i) begin
                    buf_d[{phy_idx_q, 3'b000} +: PhyW] = data_i;
                    phy_idx_d  = phy_next[AddrWidth-1:0];
                    phy_last_d = phy_last_q | last_i;
                    if (phy_next >= beat_end || last_i) begin
                        state_d = Send;
                    end
                end
            end
            Send: begin
                if (axi_ready_i) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    byte_idx_d = byte_next;
                    if (beat_last) begin
                        state_d = new_read ? Fill : Idle;
                    end else if (narrow && in_held_word) begin
                        state_d = Send;
                    end else begin
                        state_d = Fill;
                    end
                end
            end
            default: state_d = Idle;
        endcase

        // A new read is accepted in Idle or alongside the final beat handshake.
        if (new_read && ((state_q == Idle) ||
                         (state_q == Send && axi_ready_i && beat_last))) begin
            size_d     = size;
            len_d      = len;
            byte_idx_d = start_addr;
            phy_idx_d  = start_addr & ~PhyMask;
            beat_cnt_d = '0;
            phy_last_d = 1'b0;
        end

`ifdef HYPERBUS_PHY2R_ZERO_FILL_EN
        if (state_d == Fill && state_q != Fill) begin
            buf_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= Idle;
            size_q     <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            phy_idx_q  <= '0;
            beat_cnt_q <= '0;
            phy_last_q <= 1'b0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            phy_idx_q  <= phy_idx_d;
            beat_cnt_q <= beat_cnt_d;
            phy_last_q <= phy_last_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_hyperbus_phy2r.sv
// Scoreboard bench for hyperbus_phy2r at 64-bit AXI, two PHYs: directed bursts, stalls, back-to-back, reset.
module tb_hyperbus_phy2r;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [2:0]  size;
    logic [2:0]  start_addr;
    logic [7:0]  len;
    logic        is_a_read;
    logic        trans_handshake;
    logic        phy_valid_i;
    logic        phy_ready_o;
    logic [31:0] data_i;
    logic        last_i;
    logic        axi_valid_o;
    logic        axi_ready_i;
    logic [63:0] data_o;
    logic        last_o;

    hyperbus_phy2r #(
        .AxiDataWidth(64),
        .NumPhys     (2),
        .BurstLength (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .size           (size),
        .start_addr     (start_addr),
        .len            (len),
        .is_a_read      (is_a_read),
        .trans_handshake(trans_handshake),
        .phy_valid_i    (phy_valid_i),
        .phy_ready_o    (phy_ready_o),
        .data_i         (data_i),
        .last_i         (last_i),
        .axi_valid_o    (axi_valid_o),
        .axi_ready_i    (axi_ready_i),
        .data_o         (data_o),
        .last_o         (last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] d;
        logic [63:0] m;
        logic        l;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Lanes not written in a beat are only defined when the buffer is zero-filled.
    function automatic logic [63:0] lm(input logic [63:0] lanes);
`ifdef HYPERBUS_PHY2R_ZERO_FILL_EN
        return '1;
`else
        return lanes;
`endif
    endfunction

    task automatic push(input logic [63:0] d, input logic [63:0] lanes, input logic l);
        exp_t x;
        x.d = d;
        x.m = lm(lanes);
        x.l = l;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic [2:0] s, input logic [2:0] a, input logic [7:0] l);
        trans_handshake = 1'b1;
        size            = s;
        start_addr      = a;
        len             = l;
        tick();
        trans_handshake = 1'b0;
    endtask

    task automatic phy_word(input logic [31:0] w, input logic l);
        int  n    = 0;
        bit  done = 0;
        phy_valid_i = 1'b1;
        data_i      = w;
        last_i      = l;
        while (!done) begin
            @(negedge clk_i);
            if (phy_ready_o) done = 1;
            tick();
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL phy_accept_timeout actual=not_accepted required=accepted word=%h", w);
                done = 1;
            end
        end
        phy_valid_i = 1'b0;
        last_i      = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
        tick();
        tick();
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && axi_valid_o) begin
            chk("phy_ready_in_send", 64'(phy_ready_o), 64'd0);
            if (axi_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", data_o);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", data_o & e.m, e.d & e.m);
                    chk("beat_last", 64'(last_o), 64'(e.l));
                end
            end
        end
    end

    initial begin
        rst_ni          = 1'b0;
        size            = 3'd0;
        start_addr      = 3'd0;
        len             = 8'd0;
        is_a_read       = 1'b1;
        trans_handshake = 1'b0;
        phy_valid_i     = 1'b0;
        data_i          = 32'h0;
        last_i          = 1'b0;
        axi_ready_i     = 1'b1;
        #12;
        chk("rst_phy_ready", 64'(phy_ready_o), 64'd0);
        chk("rst_axi_valid", 64'(axi_valid_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        rst_ni = 1'b1;
        tick();

        // Full-width two-beat burst.
        push(64'h22222222_11111111, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        push(64'h44444444_33333333, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        start(3'd3, 3'd0, 8'd1);
        phy_word(32'h11111111, 1'b0);
        phy_word(32'h22222222, 1'b0);
        phy_word(32'h33333333, 1'b0);
        phy_word(32'h44444444, 1'b1);
        drain();

        // Unaligned single beat ending on last_i.
        push(64'hCAFEF00D_00000000, 64'hFFFFFFFF_00000000, 1'b1);
        start(3'd3, 3'd4, 8'd0);
        phy_word(32'hCAFEF00D, 1'b1);
        drain();
        chk("idle_axi_valid", 64'(axi_valid_o), 64'd0);
        chk("idle_phy_ready", 64'(phy_ready_o), 64'd0);

        // Narrow 2-byte beats; the second PHY word serves two beats.
        push(64'h00000000_A3A2A1A0, 64'h00000000_FFFF0000, 1'b0);
        push(64'hB3B2B1B0_00000000, 64'h0000FFFF_00000000, 1'b0);
        push(64'hB3B2B1B0_00000000, 64'hFFFF0000_00000000, 1'b0);
        push(64'h00000000_C3C2C1C0, 64'h00000000_0000FFFF, 1'b1);
        start(3'd1, 3'd2, 8'd3);
        phy_word(32'hA3A2A1A0, 1'b0);
        phy_word(32'hB3B2B1B0, 1'b0);
        phy_word(32'hC3C2C1C0, 1'b1);
        drain();

        // R stall: beat held, PHY blocked.
        axi_ready_i = 1'b0;
        push(64'h5A5A5A5A_12345678, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        start(3'd3, 3'd0, 8'd0);
        phy_word(32'h12345678, 1'b0);
        phy_word(32'h5A5A5A5A, 1'b1);
        phy_valid_i = 1'b1;
        data_i      = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_valid", 64'(axi_valid_o), 64'd1);
            chk("stall_data", data_o, 64'h5A5A5A5A_12345678);
            chk("stall_last", 64'(last_o), 64'd1);
            chk("stall_phy_ready", 64'(phy_ready_o), 64'd0);
        end
        tick();
        phy_valid_i = 1'b0;
        axi_ready_i = 1'b1;
        drain();

        // Back-to-back: new read accepted with the final beat, new size in effect.
        push(64'h66666666_55555555, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        push(64'h00000000_77777777, 64'h00000000_FFFFFFFF, 1'b0);
        push(64'h88888888_00000000, 64'hFFFFFFFF_00000000, 1'b1);
        start(3'd3, 3'd0, 8'd0);
        phy_word(32'h55555555, 1'b0);
        phy_word(32'h66666666, 1'b1);
        start(3'd2, 3'd0, 8'd1);
        @(negedge clk_i);
        chk("b2b_fill_ready", 64'(phy_ready_o), 64'd1);
        chk("b2b_fill_valid", 64'(axi_valid_o), 64'd0);
        tick();
        phy_word(32'h77777777, 1'b0);
        phy_word(32'h88888888, 1'b1);
        drain();

        // Reset mid-burst, then a truncated narrow burst.
        start(3'd3, 3'd0, 8'd1);
        phy_word(32'h99999999, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_phy_ready", 64'(phy_ready_o), 64'd0);
        chk("mid_rst_axi_valid", 64'(axi_valid_o), 64'd0);
        chk("mid_rst_last", 64'(last_o), 64'd0);
        chk("mid_rst_data", data_o, 64'd0);
        #2;
        rst_ni = 1'b1;
        tick();
        push(64'hBBBBBBBB_AAAAAAAA, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        start(3'd3, 3'd0, 8'd0);
        phy_word(32'hAAAAAAAA, 1'b0);
        phy_word(32'hBBBBBBBB, 1'b1);
        drain();
        push(64'h00000000_F00DFACE, 64'h00000000_0000FFFF, 1'b1);
        start(3'd1, 3'd0, 8'd3);
        phy_word(32'hF00DFACE, 1'b1);
        drain();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
